// File: rtl/pc_pkg.sv
// Shared definitions for the program counter unit: operation codes decoded by pc_unit.
package pc_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_NEXT   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_JUMP   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BRANCH = 3'd2;
  localparam logic [MODE_W-1:0] MODE_CALL   = 3'd3;
  localparam logic [MODE_W-1:0] MODE_RET    = 3'd4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO that silently drops the oldest entry on overflow,
// with sticky overflow/underflow flags. All state changes on the falling clock edge.
module pc_ras #(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_r;    // next slot to write; the top entry sits just below it
  logic [CNT_W-1:0]  cnt_r;
  logic              ovf_r;
  logic              unf_r;
  logic [PTR_W-1:0]  top_idx_s;

  assign top_idx_s = ptr_r - PTR_W'(1);
  assign top       = mem_r[top_idx_s];
  assign empty     = (cnt_r == CNT_W'(0));
  assign full      = (cnt_r == CNT_W'(RAS_DEPTH));
  assign ovf       = ovf_r;
  assign unf       = unf_r;

  // Entry storage; contents are don't-care after reset, so no reset branch here.
  always_ff @(negedge clk) begin
    if (push && !rst) begin
      mem_r[ptr_r] <= push_data;
    end
  end

  // Pointer, occupancy count and sticky flags.
  always_ff @(negedge clk) begin
    if (rst) begin
      ptr_r <= {PTR_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (push) begin
      ptr_r <= ptr_r + PTR_W'(1);
      if (full) begin
        ovf_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf_r <= 1'b1;
      end else begin
        ptr_r <= top_idx_s;
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with stall, PC-relative branch, absolute jump and call/return
// through an internal return-address stack. Updates on the falling edge of CLK.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              ADDR_W     = 8,
  parameter int              OFS_W      = 8,
  parameter int              RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              areset,
  input  logic              stall,
  input  logic [MODE_W-1:0] mode,
  input  logic              cond,
  input  logic [ADDR_W-1:0] target,
  input  logic [OFS_W-1:0]  offset,
  output logic [ADDR_W-1:0] addr_out,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] seq_s;
  logic [ADDR_W-1:0] ofs_ext_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic [ADDR_W-1:0] ras_top_s;
  logic              push_s;
  logic              pop_s;

  assign seq_s     = pc_r + ADDR_W'(1);
  assign ofs_ext_s = ADDR_W'($signed(offset));
  assign addr_out  = pc_r;

  // Next-PC selection and RAS push/pop requests; stall suppresses any RAS activity.
  always_comb begin
    next_pc_s = seq_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    case (mode)
      MODE_NEXT:   next_pc_s = seq_s;
      MODE_JUMP:   next_pc_s = target;
      MODE_BRANCH: begin
        if (cond) begin
          next_pc_s = seq_s + ofs_ext_s;
        end else begin
          next_pc_s = seq_s;
        end
      end
      MODE_CALL: begin
        next_pc_s = target;
        push_s    = !stall;
      end
      MODE_RET: begin
        pop_s = !stall;
        if (ras_empty) begin
          next_pc_s = seq_s;
        end else begin
          next_pc_s = ras_top_s;
        end
      end
      default:     next_pc_s = seq_s;
    endcase
  end

  // PC register: reset beats stall, stall beats the selected operation.
  always_ff @(negedge CLK) begin
    if (areset) begin
      pc_r <= RESET_ADDR;
    end else if (stall) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (areset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (seq_s),
    .top       (ras_top_s),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic,
// compared against a queue-based behavioural model after every falling edge.
module tb_pc_unit;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       areset;
  logic       stall;
  logic [2:0] mode;
  logic       cond;
  logic [7:0] target;
  logic [7:0] offset;
  logic [7:0] addr_out;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_ovf;
  logic       ras_unf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_pc;
  int m_stack[$];
  bit m_ovf;
  bit m_unf;

  pc_unit #(.ADDR_W(8), .OFS_W(8), .RAS_DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
    .CLK       (CLK),
    .areset    (areset),
    .stall     (stall),
    .mode      (mode),
    .cond      (cond),
    .target    (target),
    .offset    (offset),
    .addr_out  (addr_out),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int seq;
    int sext;
    seq = (m_pc + 1) % 256;
    if (areset) begin
      m_pc = 0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!stall) begin
      case (mode)
        3'd1: m_pc = target;
        3'd2: begin
          sext = int'($signed(offset));
          m_pc = cond ? ((seq + sext) & 255) : seq;
        end
        3'd3: begin
          m_stack.push_back(seq);
          if (m_stack.size() > DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = target;
        end
        3'd4: begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin
            m_pc = seq;
            m_unf = 1'b1;
          end
        end
        default: m_pc = seq;
      endcase
    end
  endtask

  // Apply inputs at a rising edge, let the falling edge update, check at the next rising edge.
  task automatic cyc(input bit rst, input bit stl, input int md, input int tgt,
                     input int ofs, input bit cnd);
    areset = rst;
    stall  = stl;
    mode   = 3'(md);
    target = 8'(tgt);
    offset = 8'(ofs);
    cond   = cnd;
    @(negedge CLK);
    model_edge();
    @(posedge CLK);
    check_eq("addr_out", int'(addr_out), m_pc);
    check_eq("ras_empty", int'(ras_empty), int'(m_stack.size() == 0));
    check_eq("ras_full", int'(ras_full), int'(m_stack.size() == DEPTH));
    check_eq("ras_ovf", int'(ras_ovf), int'(m_ovf));
    check_eq("ras_unf", int'(ras_unf), int'(m_unf));
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    areset = 1'b1; stall = 1'b0; mode = 3'd0; cond = 1'b0; target = 8'h00; offset = 8'h00;
    m_pc = 0; m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge CLK);

    // Reset and sequential fetch with wrap
    do_reset();
    check_eq("reset_pc", int'(addr_out), 'h00);
    check_eq("reset_empty", int'(ras_empty), 1);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
      check_eq("next_seq", int'(addr_out), i);
    end
    cyc(1'b0, 1'b0, 1, 'hFF, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    check_eq("next_wrap", int'(addr_out), 'h00);

    // Branches
    cyc(1'b0, 1'b0, 1, 'h10, 0, 1'b0);
    cyc(1'b0, 1'b0, 2, 0, 'hFC, 1'b1);
    check_eq("branch_back", int'(addr_out), 'h0D);
    cyc(1'b0, 1'b0, 1, 'h10, 0, 1'b0);
    cyc(1'b0, 1'b0, 2, 0, 'hFC, 1'b0);
    check_eq("branch_not_taken", int'(addr_out), 'h11);
    cyc(1'b0, 1'b0, 1, 'hFE, 0, 1'b0);
    cyc(1'b0, 1'b0, 2, 0, 'h05, 1'b1);
    check_eq("branch_wrap", int'(addr_out), 'h04);

    // Two-level call / return
    do_reset();
    cyc(1'b0, 1'b0, 1, 'h20, 0, 1'b0);
    cyc(1'b0, 1'b0, 3, 'h40, 0, 1'b0);
    check_eq("call1", int'(addr_out), 'h40);
    cyc(1'b0, 1'b0, 3, 'h60, 0, 1'b0);
    check_eq("call2", int'(addr_out), 'h60);
    cyc(1'b0, 1'b0, 4, 0, 0, 1'b0);
    check_eq("ret1", int'(addr_out), 'h41);
    cyc(1'b0, 1'b0, 4, 0, 0, 1'b0);
    check_eq("ret2", int'(addr_out), 'h21);
    check_eq("ret2_empty", int'(ras_empty), 1);
    check_eq("ret2_unf", int'(ras_unf), 0);

    // Overflow then underflow
    do_reset();
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    for (int i = 2; i <= 6; i++) cyc(1'b0, 1'b0, 3, i, 0, 1'b0);
    check_eq("ovf_full", int'(ras_full), 1);
    check_eq("ovf_flag", int'(ras_ovf), 1);
    for (int i = 6; i >= 3; i--) begin
      cyc(1'b0, 1'b0, 4, 0, 0, 1'b0);
      check_eq("ovf_ret", int'(addr_out), i);
    end
    cyc(1'b0, 1'b0, 4, 0, 0, 1'b0);
    check_eq("unf_seq", int'(addr_out), 'h04);
    check_eq("unf_flag", int'(ras_unf), 1);

    // Stall holds everything, release applies the held jump
    do_reset();
    cyc(1'b0, 1'b0, 3, 'h10, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1, 'hAA, 0, 1'b0);
      check_eq("stall_hold", int'(addr_out), 'h10);
      check_eq("stall_count", int'(ras_empty), 0);
    end
    cyc(1'b0, 1'b0, 1, 'hAA, 0, 1'b0);
    check_eq("stall_release", int'(addr_out), 'hAA);

    // Reset mid-sequence discards RAS and sticky flags
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, 3, i, 0, 1'b0);
    cyc(1'b0, 1'b0, 4, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 4, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1, 'h55, 0, 1'b0);
    check_eq("pre_reset_pc", int'(addr_out), 'h55);
    do_reset();
    check_eq("mid_reset_pc", int'(addr_out), 'h00);
    check_eq("mid_reset_empty", int'(ras_empty), 1);
    check_eq("mid_reset_ovf", int'(ras_ovf), 0);
    cyc(1'b0, 1'b0, 4, 0, 0, 1'b0);
    check_eq("post_reset_ret", int'(addr_out), 'h01);
    check_eq("post_reset_unf", int'(ras_unf), 1);

    // Random traffic, biased towards calls and returns
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int md;
      md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 4)) : int'($urandom_range(0, 7));
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), md,
          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
